// File: rtl/ddr_arb_pkg.sv
// ddr_arb_pkg: shared types and constants for the DDR command arbiter.
//   arb_state_e : arbiter FSM states
//   CMD_*       : cmd_op encodings presented to the DDR command sequencer
package ddr_arb_pkg;

  localparam int unsigned ADDR_W_DEF      = 8;
  localparam int unsigned DATA_W_DEF      = 64;
  localparam int unsigned MAX_BATCH_DEF   = 4;
  localparam int unsigned TURN_CYCLES_DEF = 2;
  localparam int unsigned SIZE_W          = 3;
  localparam int unsigned OP_W            = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    TURN = 2'd3
  } arb_state_e;

  localparam logic [OP_W-1:0] CMD_NONE = 2'b00;
  localparam logic [OP_W-1:0] CMD_WR   = 2'b01;
  localparam logic [OP_W-1:0] CMD_RD   = 2'b10;
  localparam logic [OP_W-1:0] CMD_REF  = 2'b11;

endpackage

// File: rtl/ddr_cmd_arbiter_if.sv
// ddr_cmd_arbiter_if: request/grant and command bus around the DDR command arbiter.
//   wr_*  : write front-end request, payload and grant pulse
//   rd_*  : read front-end request, payload and grant pulse
//   ref_* : refresh timer request and grant pulse
//   cmd_* : one-entry command stage towards the sequencer (valid/ready)
//   turn_active : arbiter is inserting a direction-change gap
// Modports: master = arbiter side, slave = front-ends / sequencer side.
interface ddr_cmd_arbiter_if
  import ddr_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) ();

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [SIZE_W-1:0] wr_size;
  logic              wr_grant;

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [SIZE_W-1:0] rd_size;
  logic              rd_grant;

  logic              ref_req;
  logic              ref_grant;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [SIZE_W-1:0] cmd_size;

  logic              turn_active;

  modport master (
    input  wr_req, wr_addr, wr_data, wr_size,
    input  rd_req, rd_addr, rd_size,
    input  ref_req, cmd_ready,
    output wr_grant, rd_grant, ref_grant,
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_size, turn_active
  );

  modport slave (
    output wr_req, wr_addr, wr_data, wr_size,
    output rd_req, rd_addr, rd_size,
    output ref_req, cmd_ready,
    input  wr_grant, rd_grant, ref_grant,
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_size, turn_active
  );

endinterface

// File: rtl/ddr_cmd_out_reg.sv
// ddr_cmd_out_reg: one-entry registered command stage with valid/ready.
//   clk, n_rst          : clock, synchronous active-low reset (clears entry and payload)
//   i_load              : capture i_op/i_addr/i_wdata/i_size and set o_valid
//   i_ready             : downstream accepts the entry when o_valid & i_ready
//   o_valid, o_op, ...  : registered command presented downstream
module ddr_cmd_out_reg
  import ddr_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              i_load,
  input  logic [OP_W-1:0]   i_op,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [SIZE_W-1:0] i_size,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [OP_W-1:0]   o_op,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wdata,
  output logic [SIZE_W-1:0] o_size
);

  logic              r_valid;
  logic [OP_W-1:0]   r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [SIZE_W-1:0] r_size;

  // A load always wins over a drain, so a back-to-back replace never drops a cycle.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_valid <= 1'b0;
      r_op    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_size  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_op    <= i_op;
      r_addr  <= i_addr;
      r_wdata <= i_wdata;
      r_size  <= i_size;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_op    = r_op;
  assign o_addr  = r_addr;
  assign o_wdata = r_wdata;
  assign o_size  = r_size;

endmodule

// File: rtl/ddr_cmd_arbiter.sv
// ddr_cmd_arbiter: shares the DDR command port between write, read and refresh.
//   clk, n_rst : clock, synchronous active-low reset
//   bus        : ddr_cmd_arbiter_if.master (requests/grants in, command stage out)
// Writes and reads are batched up to MAX_BATCH grants while the other side waits;
// every direction change inserts TURN_CYCLES idle cycles. Refresh preempts batching.
module ddr_cmd_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned MAX_BATCH   = MAX_BATCH_DEF,
  parameter int unsigned TURN_CYCLES = TURN_CYCLES_DEF
) (
  input logic                clk,
  input logic                n_rst,
  ddr_cmd_arbiter_if.master  bus
);

  localparam int unsigned BATCH_W = $clog2(MAX_BATCH + 1);
  localparam int unsigned TURN_W  = $clog2(TURN_CYCLES + 1);

  arb_state_e        r_state;
  arb_state_e        r_turn_target;
  logic [BATCH_W-1:0] r_batch_cnt;
  logic [TURN_W-1:0]  r_turn_cnt;

  logic              w_load_ok;
  logic              w_batch_room;
  logic              w_decide;
  logic              w_wr_gnt;
  logic              w_rd_gnt;
  logic              w_ref_gnt;
  logic              w_load;
  logic [OP_W-1:0]   w_ld_op;
  logic [ADDR_W-1:0] w_ld_addr;
  logic [DATA_W-1:0] w_ld_wdata;
  logic [SIZE_W-1:0] w_ld_size;
  logic [BATCH_W-1:0] w_batch_inc;

  logic              w_cmd_valid;
  logic [OP_W-1:0]   w_cmd_op;
  logic [ADDR_W-1:0] w_cmd_addr;
  logic [DATA_W-1:0] w_cmd_wdata;
  logic [SIZE_W-1:0] w_cmd_size;

  assign w_load_ok    = ~w_cmd_valid | bus.cmd_ready;
  assign w_batch_room = r_batch_cnt < BATCH_W'(MAX_BATCH);
  assign w_batch_inc  = w_batch_room ? r_batch_cnt + BATCH_W'(1) : r_batch_cnt;
  // FSM direction decisions are only taken on load_ok cycles not claimed by refresh.
  assign w_decide     = w_load_ok & ~w_ref_gnt;

  // Grant selection: refresh first (outside TURN), then the batching rules.
  always_comb begin
    w_wr_gnt  = 1'b0;
    w_rd_gnt  = 1'b0;
    w_ref_gnt = 1'b0;
    if (n_rst && w_load_ok) begin
      if (bus.ref_req && (r_state != TURN)) begin
        w_ref_gnt = 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            if (bus.rd_req)      w_rd_gnt = 1'b1;
            else if (bus.wr_req) w_wr_gnt = 1'b1;
          end
          WR: w_wr_gnt = bus.wr_req & (w_batch_room | ~bus.rd_req);
          RD: w_rd_gnt = bus.rd_req & (w_batch_room | ~bus.wr_req);
          default: ;
        endcase
      end
    end
  end

  // Payload mux for the winning requester; unused fields are zeroed.
  always_comb begin
    w_ld_op    = CMD_NONE;
    w_ld_addr  = '0;
    w_ld_wdata = '0;
    w_ld_size  = '0;
    if (w_wr_gnt) begin
      w_ld_op    = CMD_WR;
      w_ld_addr  = bus.wr_addr;
      w_ld_wdata = bus.wr_data;
      w_ld_size  = bus.wr_size;
    end else if (w_rd_gnt) begin
      w_ld_op    = CMD_RD;
      w_ld_addr  = bus.rd_addr;
      w_ld_size  = bus.rd_size;
    end else if (w_ref_gnt) begin
      w_ld_op    = CMD_REF;
    end
  end

  assign w_load = w_wr_gnt | w_rd_gnt | w_ref_gnt;

  // Arbiter FSM; the TURN countdown runs every cycle regardless of backpressure.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state       <= IDLE;
      r_turn_target <= IDLE;
      r_batch_cnt   <= '0;
      r_turn_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_rd_gnt) begin
            r_state     <= RD;
            r_batch_cnt <= BATCH_W'(1);
          end else if (w_wr_gnt) begin
            r_state     <= WR;
            r_batch_cnt <= BATCH_W'(1);
          end
        end
        WR: begin
          if (w_wr_gnt) begin
            r_batch_cnt <= w_batch_inc;
          end else if (w_decide && bus.rd_req) begin
            r_state       <= TURN;
            r_turn_cnt    <= TURN_W'(TURN_CYCLES);
            r_turn_target <= RD;
          end
        end
        RD: begin
          if (w_rd_gnt) begin
            r_batch_cnt <= w_batch_inc;
          end else if (w_decide && bus.wr_req) begin
            r_state       <= TURN;
            r_turn_cnt    <= TURN_W'(TURN_CYCLES);
            r_turn_target <= WR;
          end
        end
        default: begin
          if (r_turn_cnt <= TURN_W'(1)) begin
            r_state     <= r_turn_target;
            r_batch_cnt <= '0;
            r_turn_cnt  <= '0;
          end else begin
            r_turn_cnt  <= r_turn_cnt - TURN_W'(1);
          end
        end
      endcase
    end
  end

  ddr_cmd_out_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk     (clk),
    .n_rst   (n_rst),
    .i_load  (w_load),
    .i_op    (w_ld_op),
    .i_addr  (w_ld_addr),
    .i_wdata (w_ld_wdata),
    .i_size  (w_ld_size),
    .i_ready (bus.cmd_ready),
    .o_valid (w_cmd_valid),
    .o_op    (w_cmd_op),
    .o_addr  (w_cmd_addr),
    .o_wdata (w_cmd_wdata),
    .o_size  (w_cmd_size)
  );

  assign bus.wr_grant    = w_wr_gnt;
  assign bus.rd_grant    = w_rd_gnt;
  assign bus.ref_grant   = w_ref_gnt;
  assign bus.cmd_valid   = w_cmd_valid;
  assign bus.cmd_op      = w_cmd_op;
  assign bus.cmd_addr    = w_cmd_addr;
  assign bus.cmd_wdata   = w_cmd_wdata;
  assign bus.cmd_size    = w_cmd_size;
  assign bus.turn_active = (r_state == TURN);

endmodule

// File: tb/tb_ddr_cmd_arbiter.sv
// tb_ddr_cmd_arbiter: directed bench for ddr_cmd_arbiter (MAX_BATCH=4, TURN_CYCLES=2).
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_ddr_cmd_arbiter;
  import ddr_arb_pkg::*;

  localparam int unsigned ADDR_W      = 8;
  localparam int unsigned DATA_W      = 64;
  localparam int unsigned MAX_BATCH   = 4;
  localparam int unsigned TURN_CYCLES = 2;

  logic clk;
  logic n_rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  ddr_cmd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ddr_cmd_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .MAX_BATCH   (MAX_BATCH),
    .TURN_CYCLES (TURN_CYCLES)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Expected per-cycle pattern {turn_active, ref, rd, wr} with both requests held.
  logic [3:0] pat [0:18];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  function automatic logic [2:0] gnts();
    return {bus.ref_grant, bus.rd_grant, bus.wr_grant};
  endfunction

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    bus.wr_req    = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.wr_size   = '0;
    bus.rd_req    = 1'b0;
    bus.rd_addr   = '0;
    bus.rd_size   = '0;
    bus.ref_req   = 1'b0;
    bus.cmd_ready = 1'b1;
  endtask

  // Leaves the bench at a drive point with n_rst released and the DUT in IDLE.
  task automatic apply_reset();
    clr_in();
    n_rst = 1'b0;
    nxt();
    nxt();
    n_rst = 1'b1;
  endtask

  initial begin
    pat = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b1000, 4'b1000,
            4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b1000, 4'b1000,
            4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000};

    // Reset state, with a pending write that must not be granted during reset.
    clr_in();
    n_rst = 1'b0;
    bus.wr_req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt",   64'(gnts()),        64'd0);
    chk("rst_valid", 64'(bus.cmd_valid), 64'd0);
    chk("rst_op",    64'(bus.cmd_op),    64'd0);
    chk("rst_addr",  64'(bus.cmd_addr),  64'd0);
    chk("rst_turn",  64'(bus.turn_active), 64'd0);

    // Single write: grant in cycle 0, command visible in cycle 1.
    nxt();
    n_rst       = 1'b1;
    bus.wr_addr = 8'h10;
    bus.wr_data = 64'hDEAD_BEEF;
    bus.wr_size = 3'd3;
    @(negedge clk);
    chk("wr1_gnt",    64'(gnts()),        64'd1);
    chk("wr1_valid0", 64'(bus.cmd_valid), 64'd0);
    nxt();
    bus.wr_req = 1'b0;
    @(negedge clk);
    chk("wr1_valid", 64'(bus.cmd_valid), 64'd1);
    chk("wr1_op",    64'(bus.cmd_op),    64'd1);
    chk("wr1_addr",  64'(bus.cmd_addr),  64'h10);
    chk("wr1_wdata", bus.cmd_wdata,      64'hDEAD_BEEF);
    chk("wr1_size",  64'(bus.cmd_size),  64'd3);
    chk("wr1_gnt_n", 64'(gnts()),        64'd0);
    nxt();
    @(negedge clk);
    chk("wr1_drain", 64'(bus.cmd_valid), 64'd0);

    // Both directions held: reads first, batches of 4, 2-cycle turnarounds.
    apply_reset();
    bus.rd_req  = 1'b1;
    bus.rd_addr = 8'h20;
    bus.rd_size = 3'd2;
    bus.wr_req  = 1'b1;
    bus.wr_addr = 8'h30;
    bus.wr_data = 64'h5555;
    bus.wr_size = 3'd3;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      chk($sformatf("alt_gnt[%0d]", i),  64'(gnts()),           64'(pat[i][2:0]));
      chk($sformatf("alt_turn[%0d]", i), 64'(bus.turn_active),  64'(pat[i][3]));
      if (i > 0) begin
        chk($sformatf("alt_valid[%0d]", i), 64'(bus.cmd_valid), 64'(|pat[i-1][2:0]));
        if (|pat[i-1][2:0])
          chk($sformatf("alt_op[%0d]", i), 64'(bus.cmd_op),
              pat[i-1][1] ? 64'd2 : 64'd1);
      end
      nxt();
    end

    // Refresh mid write batch, then refresh raised during TURN.
    apply_reset();
    bus.wr_req  = 1'b1;
    bus.wr_addr = 8'h50;
    @(negedge clk); chk("ref_w0", 64'(gnts()), 64'd1);
    nxt();
    @(negedge clk); chk("ref_w1", 64'(gnts()), 64'd1);
    nxt();
    bus.ref_req = 1'b1;
    @(negedge clk); chk("ref_gnt", 64'(gnts()), 64'd4);
    nxt();
    bus.ref_req = 1'b0;
    bus.rd_req  = 1'b1;
    @(negedge clk);
    chk("ref_w2",    64'(gnts()),       64'd1);
    chk("ref_op",    64'(bus.cmd_op),   64'd3);
    chk("ref_addr",  64'(bus.cmd_addr), 64'd0);
    chk("ref_wdata", bus.cmd_wdata,     64'd0);
    nxt();
    @(negedge clk);
    chk("ref_w3",    64'(gnts()),       64'd1);
    chk("ref_w2_op", 64'(bus.cmd_op),   64'd1);
    nxt();
    @(negedge clk);
    chk("ref_dec_gnt",  64'(gnts()),           64'd0);
    chk("ref_dec_turn", 64'(bus.turn_active),  64'd0);
    nxt();
    bus.ref_req = 1'b1;
    @(negedge clk);
    chk("ref_t0_gnt",  64'(gnts()),          64'd0);
    chk("ref_t0_turn", 64'(bus.turn_active), 64'd1);
    nxt();
    @(negedge clk);
    chk("ref_t1_gnt",  64'(gnts()),          64'd0);
    chk("ref_t1_turn", 64'(bus.turn_active), 64'd1);
    nxt();
    @(negedge clk);
    chk("ref_post_gnt",  64'(gnts()),          64'd4);
    chk("ref_post_turn", 64'(bus.turn_active), 64'd0);
    nxt();
    bus.ref_req = 1'b0;
    @(negedge clk);
    chk("ref_rd_gnt", 64'(gnts()),     64'd2);
    chk("ref_rd_op",  64'(bus.cmd_op), 64'd3);
    nxt();

    // Backpressure: cmd_ready low for 5 cycles holds the stage and stalls grants.
    apply_reset();
    bus.cmd_ready = 1'b0;
    bus.wr_req    = 1'b1;
    bus.wr_addr   = 8'h40;
    bus.wr_data   = 64'h1111;
    bus.wr_size   = 3'd1;
    @(negedge clk); chk("bp_gnt0", 64'(gnts()), 64'd1);
    nxt();
    bus.wr_addr = 8'h44;
    bus.wr_data = 64'h2222;
    bus.wr_size = 3'd2;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_gnt[%0d]", k),   64'(gnts()),        64'd0);
      chk($sformatf("bp_valid[%0d]", k), 64'(bus.cmd_valid), 64'd1);
      chk($sformatf("bp_addr[%0d]", k),  64'(bus.cmd_addr),  64'h40);
      chk($sformatf("bp_wdata[%0d]", k), bus.cmd_wdata,      64'h1111);
      nxt();
    end
    bus.cmd_ready = 1'b1;
    @(negedge clk); chk("bp_release_gnt", 64'(gnts()), 64'd1);
    nxt();
    bus.wr_req = 1'b0;
    @(negedge clk);
    chk("bp2_addr",  64'(bus.cmd_addr), 64'h44);
    chk("bp2_wdata", bus.cmd_wdata,     64'h2222);
    chk("bp2_size",  64'(bus.cmd_size), 64'd2);
    nxt();

    // Reset while a read is held in the output stage.
    apply_reset();
    bus.cmd_ready = 1'b0;
    bus.rd_req    = 1'b1;
    bus.rd_addr   = 8'h77;
    bus.rd_size   = 3'd1;
    @(negedge clk); chk("mrst_rd_gnt", 64'(gnts()), 64'd2);
    nxt();
    bus.rd_req = 1'b0;
    @(negedge clk);
    chk("mrst_valid1", 64'(bus.cmd_valid), 64'd1);
    chk("mrst_op1",    64'(bus.cmd_op),    64'd2);
    nxt();
    n_rst = 1'b0;
    @(negedge clk);
    nxt();
    n_rst         = 1'b1;
    bus.cmd_ready = 1'b1;
    bus.wr_req    = 1'b1;
    bus.wr_addr   = 8'h12;
    @(negedge clk);
    chk("mrst_valid", 64'(bus.cmd_valid),   64'd0);
    chk("mrst_op",    64'(bus.cmd_op),      64'd0);
    chk("mrst_addr",  64'(bus.cmd_addr),    64'd0);
    chk("mrst_size",  64'(bus.cmd_size),    64'd0);
    chk("mrst_turn",  64'(bus.turn_active), 64'd0);
    chk("mrst_wgnt",  64'(gnts()),          64'd1);
    nxt();
    bus.wr_req = 1'b0;
    @(negedge clk);
    chk("mrst_w_op",   64'(bus.cmd_op),   64'd1);
    chk("mrst_w_addr", 64'(bus.cmd_addr), 64'h12);
    nxt();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
